approx_mult_pipe: RTL
=====================

Name: approx_mult_pipe

Overview:
- Parametrised, pipelined unsigned approximate multiplier; successor to the fixed 8x8, two-row-truncation combinational multipliers.
- Drops the low L rows of the x-operand partial-product array, adds OR-based carry compensation, and can be switched to exact per transaction.
- Sits between operand producers and accumulator/datapath consumers behind valid/ready handshakes.

Parameters:
- W, 8, operand width (W >= 4).
- L, 2, number of truncated low x rows (1 <= L <= W-2).
- COMP_COLS, 2, number of compensation columns ending at column W-1 (1 <= COMP_COLS <= W-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_x  in  W  multiplier operand.
- in_y  in  W  multiplicand operand.
- in_exact  in  1  1 = exact product for this beat, 0 = approximate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_z  out  2W  product.
- out_exact  out  1  mode tag carried with the result.

Behaviour:
- Approximate product: z = ((y * x[W-1:L]) << L) + comp.
- comp bit c+1 = OR over i in [0, L-1] with 0 <= c-i <= W-1 of (x[i] & y[c-i]), for c in [W-COMP_COLS, W-1]. All other comp bits are 0.
- Exact product: z = x * y.
- Result is full 2W bits and never overflows; the approximate result may exceed the exact one.
- Pipeline has 2 register stages:
  - S1: registered x, y, mode, comp vector, truncated partial product (y * x[W-1:L]).
  - S2: shift/add (or exact product) and output register.
- Latency: accepted beat appears on out_valid exactly 2 cycles later when there is no backpressure.
- Handshake:
  - Beat transfers when valid && ready.
  - in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready.
  - Full throughput: 1 beat/cycle.
  - out_z and out_exact are held stable while out_valid && !out_ready.
  - Upstream data must not be consumed unless in_ready is high.
  - Bubbles propagate: a stage with valid = 0 never asserts downstream valid.
- Simultaneous accept at the input and drain at the output in one cycle is legal; no beat is lost or duplicated.
- Reset (asynchronous, any time including mid-transaction):
  - Discards all in-flight beats.
  - out_valid = 0, out_z = 0, out_exact = 0, all stage valids = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- in_exact is sampled with its beat; changing it between beats never affects in-flight beats.

Optional Feature:
- Macro: APPROX_MULT_ERR_STAT_EN.
- When defined, adds ports:
  - stat_clr (in, 1)
  - err_sum (out, 2W+16): saturating sum of |exact - approx|.
  - err_max (out, 2W): max |exact - approx|.
  - stat_cnt (out, 16): saturating count of approximate beats.
- Statistics update on each output transfer whose beat is approximate; exact beats are not counted.
- stat_clr zeroes all three counters synchronously and takes priority over an update in the same cycle.
- Reset zeroes all three counters.
- When not defined, none of these ports or registers exist, and the core behaviour is identical.

Decomposition:
- Package approx_mult_pkg:
  - Stage-record typedef (valid, exact, x, y, comp, partial).
  - Width-helper localparams (PW = 2W).
  - Function comp_vec(x, y) implementing the compensation rule.
- One sub-module: approx_mult_comp, purely combinational compensation generator, reusable by other approximate multipliers.

Test Plan:
- W=8, L=2, COMP_COLS=2, approximate: x=255, y=255 -> out_z=64644 (exact 65025), two cycles after accept.
- x=3, y=255, approximate -> out_z=384; same operands with in_exact=1 -> out_z=765, out_exact=1.
- x=4, y=5, approximate -> 20; x=1, y=128, approximate -> 256 (overestimate case, error -128).
- Back-to-back stream of 16 random beats with out_ready held low for 3 cycles mid-stream:
  - Results are in order with none lost or duplicated.
  - in_ready falls within 2 cycles of the stall.
  - out_z is stable during the stall.
- Assert rst with 2 beats in flight -> out_valid=0 immediately; after release, the first new beat x=2, y=3 yields 6 with no stale results.
- With APPROX_MULT_ERR_STAT_EN: beats (255,255) and (1,128) approximate, plus (3,255) exact -> stat_cnt=2, err_sum=509, err_max=381; then stat_clr -> all 0.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared types, width helpers and the compensation rule
// for the approximate multiplier family. Values here describe the default
// 8x8 configuration; parametrised blocks derive their own widths from W/L.
package approx_mult_pkg;

  localparam int W_DEF         = 8;
  localparam int L_DEF         = 2;
  localparam int COMP_COLS_DEF = 2;
  localparam int PW            = 2 * W_DEF;

  // One pipeline stage record for the default configuration.
  typedef struct packed {
    logic                     valid;
    logic                     exact;
    logic [W_DEF-1:0]         x;
    logic [W_DEF-1:0]         y;
    logic [W_DEF:0]           comp;
    logic [PW-L_DEF-1:0]      partial;
  } stage_t;

  // OR-compensation for the dropped low x rows: bit c+1 collects every
  // dropped partial-product bit that lands in column c, for the top
  // COMP_COLS columns below W.
  function automatic logic [W_DEF:0] comp_vec(input logic [W_DEF-1:0] x,
                                              input logic [W_DEF-1:0] y);
    logic [W_DEF:0] v;
    v = '0;
    for (int c = W_DEF - COMP_COLS_DEF; c < W_DEF; c++) begin
      for (int i = 0; i < L_DEF; i++) begin
        if (c >= i) begin
          v[c+1] = v[c+1] | (x[i] & (|(y & ({{(W_DEF-1){1'b0}}, 1'b1} << (c - i)))));
        end
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/approx_mult_comp.sv
// approx_mult_comp: combinational OR-compensation vector for a multiplier
// that truncates its low L x rows. Reusable by any truncated multiplier.
module approx_mult_comp
  import approx_mult_pkg::*;
#(
  parameter int W         = 8,
  parameter int L         = 2,
  parameter int COMP_COLS = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W:0]   comp
);

  // Column c of a dropped row i holds x[i] & y[c-i]; OR them into bit c+1.
  always_comb begin
    comp = '0;
    for (int c = W - COMP_COLS; c < W; c++) begin
      for (int i = 0; i < L; i++) begin
        if (c >= i) begin
          comp[c+1] = comp[c+1] | (x[i] & (|(y & ({{(W-1){1'b0}}, 1'b1} << (c - i)))));
        end
      end
    end
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: two-stage pipelined unsigned approximate multiplier
// with valid/ready on both sides and a per-beat exact/approximate select.
// Optional macro APPROX_MULT_ERR_STAT_EN adds error statistics
// (stat_clr, err_sum, err_max, stat_cnt) over approximate output beats.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W         = 8,
  parameter int L         = 2,
  parameter int COMP_COLS = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic           in_exact,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_z,
  output logic           out_exact
`ifdef APPROX_MULT_ERR_STAT_EN
  ,
  input  logic            stat_clr,
  output logic [2*W+15:0] err_sum,
  output logic [2*W-1:0]  err_max,
  output logic [15:0]     stat_cnt
`endif
);

  localparam int ZW = 2 * W;

  typedef struct packed {
    logic              valid;
    logic              exact;
    logic [W-1:0]      x;
    logic [W-1:0]      y;
    logic [W:0]        comp;
    logic [ZW-L-1:0]   partial;
  } stage_rec_t;

  stage_rec_t       s1;
  logic [W:0]       comp_c;
  logic [ZW-L-1:0]  partial_c;
  logic [ZW-1:0]    approx_z;
  logic [ZW-1:0]    exact_z;
  logic             s2_advance;

  approx_mult_comp #(
    .W         (W),
    .L         (L),
    .COMP_COLS (COMP_COLS)
  ) u_comp (
    .x    (in_x),
    .y    (in_y),
    .comp (comp_c)
  );

  assign partial_c  = {{(W-L){1'b0}}, in_y} * {{W{1'b0}}, in_x[W-1:L]};
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1.valid || s2_advance;

  // Stage 1: capture operands, mode, compensation and truncated partial.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (in_ready) begin
      s1.valid <= in_valid;
      if (in_valid) begin
        s1.exact   <= in_exact;
        s1.x       <= in_x;
        s1.y       <= in_y;
        s1.comp    <= comp_c;
        s1.partial <= partial_c;
      end
    end
  end

  assign approx_z = {s1.partial, {L{1'b0}}} + {{(W-1){1'b0}}, s1.comp};
  assign exact_z  = {{W{1'b0}}, s1.x} * {{W{1'b0}}, s1.y};

  // Stage 2: output register; data only moves when a real beat advances,
  // so out_z/out_exact stay put under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_exact <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1.valid;
      if (s1.valid) begin
        out_z     <= s1.exact ? exact_z : approx_z;
        out_exact <= s1.exact;
      end
    end
  end

`ifdef APPROX_MULT_ERR_STAT_EN
  logic [ZW-1:0]  err_c;
  logic [ZW-1:0]  err_q;
  logic [ZW+16:0] sum_next;

  assign err_c    = (exact_z >= approx_z) ? (exact_z - approx_z) : (approx_z - exact_z);
  assign sum_next = {1'b0, err_sum} + {17'd0, err_q};

  // Error magnitude travels alongside the result it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (s2_advance && s1.valid) begin
      err_q <= err_c;
    end
  end

  // Statistics over approximate beats leaving the block; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum  <= '0;
      err_max  <= '0;
      stat_cnt <= '0;
    end else if (stat_clr) begin
      err_sum  <= '0;
      err_max  <= '0;
      stat_cnt <= '0;
    end else if (out_valid && out_ready && !out_exact) begin
      err_sum <= sum_next[ZW+16] ? '1 : sum_next[ZW+15:0];
      if (err_q > err_max) err_max <= err_q;
      if (stat_cnt != 16'hFFFF) stat_cnt <= stat_cnt + 16'd1;
    end
  end
`endif

endmodule
